// File: rtl/costas_pkg.sv
// Shared constants, lock-state type and saturating helpers for the Costas loop filter.
package costas_pkg;

    // Error sample format, matching the phase-error detector output.
    localparam int unsigned SYM_WIDTH  = 1;
    localparam int unsigned INT_WIDTH  = 1;
    localparam int unsigned DEC_WIDTH  = 14;
    localparam int unsigned DATA_WIDTH = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;

    // Integrator / NCO control word width.
    localparam int unsigned ACC_WIDTH  = 32;
    localparam int unsigned ALIGN_SHIFT = ACC_WIDTH - DATA_WIDTH;

    // Loop gains expressed as right-shift amounts.
    localparam int unsigned C1_SHIFT_ACQ = 4;
    localparam int unsigned C2_SHIFT_ACQ = 10;
    localparam int unsigned C1_SHIFT_TRK = 6;
    localparam int unsigned C2_SHIFT_TRK = 14;

    // Lock detection.
    localparam logic [DATA_WIDTH-1:0] LOCK_THRESH = 16'h0200;
    localparam int unsigned LOCK_CNT   = 64;
    localparam int unsigned UNLOCK_CNT = 16;
    localparam int unsigned CNT_WIDTH  =
        $clog2((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT);

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } lock_state_t;

    // Clamp a one-bit-wider sum back into the signed ACC_WIDTH range.
    function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] s);
        logic [ACC_WIDTH-1:0] r;
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            r = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Magnitude of a signed error sample; the most negative code maps to the largest positive.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] e);
        logic [DATA_WIDTH-1:0] r;
        if (e == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (e[DATA_WIDTH-1]) begin
            r = (~e) + 1'b1;
        end else begin
            r = e;
        end
        return r;
    endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// Sample-in / control-word-out bundle of the Costas loop filter.
interface costas_loop_filter_if;
    import costas_pkg::*;

    logic                  LoopFilterInputValid;
    logic [DATA_WIDTH-1:0] LoopFilterInputData;
    logic                  LoopFilterClear;
    logic                  LoopFilterOutputValid;
    logic [ACC_WIDTH-1:0]  LoopFilterOutputData;
    logic                  LoopFilterLocked;

    // Driver of error samples / consumer of the control word.
    modport master (
        output LoopFilterInputValid,
        output LoopFilterInputData,
        output LoopFilterClear,
        input  LoopFilterOutputValid,
        input  LoopFilterOutputData,
        input  LoopFilterLocked
    );

    // The loop filter itself.
    modport slave (
        input  LoopFilterInputValid,
        input  LoopFilterInputData,
        input  LoopFilterClear,
        output LoopFilterOutputValid,
        output LoopFilterOutputData,
        output LoopFilterLocked
    );

endinterface

// File: rtl/costas_lock_detector.sv
// Lock detector: counts consecutive in/out-of-lock error samples and switches
// between wide-gain acquisition and narrow-gain tracking.
module costas_lock_detector
    import costas_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  clear,
    output lock_state_t           state
);

    lock_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_lock;

    // Strictly-below-threshold magnitude counts as in lock.
    always_comb begin
        in_lock = (abs_sat(sample) < LOCK_THRESH);
    end

    // Next state / counter; clear overrides any simultaneous sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
        end else if (sample_valid) begin
            case (state_q)
                ACQUIRE: begin
                    if (!in_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_WIDTH'(LOCK_CNT - 1)) begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (in_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_WIDTH'(UNLOCK_CNT - 1)) begin
                        state_d = ACQUIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACQUIRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/costas_loop_filter.sv
// Second-order (PI) loop filter for the MPSK Costas loop. Two-stage pipeline:
// stage 1 forms the proportional term and updates the integrator, stage 2 sums
// them into the saturated NCO frequency-control word.
module costas_loop_filter
    import costas_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    costas_loop_filter_if.slave  lf
);

    lock_state_t                  lock_state;
    logic                         accept;
    logic signed [ACC_WIDTH-1:0]  e_ext;
    logic signed [ACC_WIDTH-1:0]  prop_d;
    logic signed [ACC_WIDTH-1:0]  integ_inc;
    logic        [ACC_WIDTH:0]    integ_sum;
    logic        [ACC_WIDTH-1:0]  integ_d;
    logic        [ACC_WIDTH:0]    out_sum;
    logic        [ACC_WIDTH-1:0]  out_d;

    logic                         v1_q;
    logic signed [ACC_WIDTH-1:0]  prop_q;
    logic signed [ACC_WIDTH-1:0]  integ_q;
    logic                         v2_q;
    logic        [ACC_WIDTH-1:0]  out_q;
    logic                         locked_q;

    costas_lock_detector u_lock (
        .clk          (clk),
        .rstn         (rstn),
        .sample_valid (lf.LoopFilterInputValid),
        .sample       (lf.LoopFilterInputData),
        .clear        (lf.LoopFilterClear),
        .state        (lock_state)
    );

    // Stage-1 datapath: gains come from the lock state before this sample.
    always_comb begin
        accept    = lf.LoopFilterInputValid & ~lf.LoopFilterClear;
        e_ext     = signed'({lf.LoopFilterInputData, {ALIGN_SHIFT{1'b0}}});
        if (lock_state == TRACK) begin
            prop_d    = e_ext >>> C1_SHIFT_TRK;
            integ_inc = e_ext >>> C2_SHIFT_TRK;
        end else begin
            prop_d    = e_ext >>> C1_SHIFT_ACQ;
            integ_inc = e_ext >>> C2_SHIFT_ACQ;
        end
        integ_sum = {integ_q[ACC_WIDTH-1], integ_q} + {integ_inc[ACC_WIDTH-1], integ_inc};
        integ_d   = sat_acc(integ_sum);
    end

    // Stage-2 datapath: always uses the already-updated integrator.
    always_comb begin
        out_sum = {integ_q[ACC_WIDTH-1], integ_q} + {prop_q[ACC_WIDTH-1], prop_q};
        out_d   = sat_acc(out_sum);
    end

    // Stage-1 registers; clear empties the integrator and drops the stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            prop_q  <= '0;
            integ_q <= '0;
        end else if (lf.LoopFilterClear) begin
            v1_q    <= 1'b0;
            integ_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                prop_q  <= prop_d;
                integ_q <= signed'(integ_d);
            end
        end
    end

    // Stage-2 registers; output word holds between strobes and across clear.
    // Locked trails the detector by one cycle so it lines up with the triggering output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q     <= 1'b0;
            out_q    <= '0;
            locked_q <= 1'b0;
        end else if (lf.LoopFilterClear) begin
            v2_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            v2_q     <= v1_q;
            locked_q <= (lock_state == TRACK);
            if (v1_q) begin
                out_q <= out_d;
            end
        end
    end

    assign lf.LoopFilterOutputValid = v2_q;
    assign lf.LoopFilterOutputData  = out_q;
    assign lf.LoopFilterLocked      = locked_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed bench for costas_loop_filter: single-sample vector table plus
// hand-written gap, back-to-back, saturation, lock, clear and reset sequences.
module tb_costas_loop_filter;
    import costas_pkg::*;

    logic clk = 1'b0;
    logic rstn;

    costas_loop_filter_if lf ();

    costas_loop_filter dut (
        .clk  (clk),
        .rstn (rstn),
        .lf   (lf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] e;
        logic [31:0] exp_out;
        logic        exp_locked;
    } vec_t;

    vec_t vecs [7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One sample; output must appear exactly two cycles after it is captured.
    task automatic push(input logic [15:0] e, output logic timing_ok,
                        output logic [31:0] out, output logic lk);
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b1;
        lf.LoopFilterInputData  = e;
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b0;
        @(negedge clk);
        timing_ok = (lf.LoopFilterOutputValid === 1'b0);
        @(negedge clk);
        timing_ok = timing_ok && (lf.LoopFilterOutputValid === 1'b1);
        out = lf.LoopFilterOutputData;
        lk  = lf.LoopFilterLocked;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        lf.LoopFilterClear = 1'b1;
        @(posedge clk); #1;
        lf.LoopFilterClear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t, lk, ok, mono;
        logic [31:0] o, prev;
        logic        vq [5];
        logic [31:0] oq [5];

        vecs[0] = '{16'h0400, 32'h0041_0000, 1'b0};
        vecs[1] = '{16'hFC00, 32'hFFBF_0000, 1'b0};
        vecs[2] = '{16'h0001, 32'h0000_1040, 1'b0};
        vecs[3] = '{16'hFFFF, 32'hFFFF_EFC0, 1'b0};
        vecs[4] = '{16'h7FFF, 32'h081F_EFC0, 1'b0};
        vecs[5] = '{16'h8000, 32'hF7E0_0000, 1'b0};
        vecs[6] = '{16'h0000, 32'h0000_0000, 1'b0};

        lf.LoopFilterInputValid = 1'b0;
        lf.LoopFilterInputData  = '0;
        lf.LoopFilterClear      = 1'b0;
        rstn = 1'b0;
        #12;
        check("reset_valid",  {31'b0, lf.LoopFilterOutputValid}, 32'd0);
        check("reset_data",   lf.LoopFilterOutputData, 32'd0);
        check("reset_locked", {31'b0, lf.LoopFilterLocked}, 32'd0);
        rstn = 1'b1;

        // First sample and latency.
        push(16'h0400, t, o, lk);
        check("t1_timing", {31'b0, t}, 32'd1);
        check("t1_data", o, 32'h0041_0000);
        check("t1_locked", {31'b0, lk}, 32'd0);

        // Idle gap: no strobe, data holds, then the second sample continues the integral.
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (lf.LoopFilterOutputValid !== 1'b0 || lf.LoopFilterOutputData !== 32'h0041_0000)
                ok = 1'b0;
        end
        check("t2_gap_hold", {31'b0, ok}, 32'd1);
        push(16'h0400, t, o, lk);
        check("t2_timing", {31'b0, t}, 32'd1);
        check("t2_data", o, 32'h0042_0000);

        // Vector table, each from a cleared loop.
        for (int i = 0; i < 7; i++) begin
            do_clear();
            push(vecs[i].e, t, o, lk);
            check($sformatf("vec%0d_timing", i), {31'b0, t}, 32'd1);
            check($sformatf("vec%0d_data", i), o, vecs[i].exp_out);
            check($sformatf("vec%0d_locked", i), {31'b0, lk}, {31'b0, vecs[i].exp_locked});
        end

        // Back-to-back samples on consecutive cycles.
        do_clear();
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b1;
        lf.LoopFilterInputData  = 16'h0400;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) lf.LoopFilterInputValid = 1'b0;
            @(negedge clk);
            vq[k] = lf.LoopFilterOutputValid;
            oq[k] = lf.LoopFilterOutputData;
        end
        check("b2b_v0", {31'b0, vq[0]}, 32'd0);
        check("b2b_o1", oq[1], 32'h0041_0000);
        check("b2b_o2", oq[2], 32'h0042_0000);
        check("b2b_o3", oq[3], 32'h0043_0000);
        check("b2b_valid_run", {29'b0, vq[1], vq[2], vq[3]}, 32'd7);
        check("b2b_v4", {31'b0, vq[4]}, 32'd0);
        check("b2b_hold4", oq[4], 32'h0043_0000);

        // Positive then negative saturation: monotonic, clamps, never wraps.
        do_clear();
        ok = 1'b1; mono = 1'b1; prev = 32'd0;
        for (int i = 0; i < 2000; i++) begin
            push(16'h7FFF, t, o, lk);
            ok = ok && t;
            if (o[31] || (i > 0 && $signed(o) < $signed(prev))) mono = 1'b0;
            prev = o;
        end
        check("sat_up_timing", {31'b0, ok}, 32'd1);
        check("sat_up_monotonic", {31'b0, mono}, 32'd1);
        check("sat_up_final", o, 32'h7FFF_FFFF);
        mono = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            push(16'h8000, t, o, lk);
            if ($signed(o) > $signed(prev)) mono = 1'b0;
            prev = o;
        end
        check("sat_dn_monotonic", {31'b0, mono}, 32'd1);
        check("sat_dn_final", o, 32'h8000_0000);
        check("sat_dn_locked", {31'b0, lk}, 32'd0);

        // Lock acquisition: 64 in-lock samples, then a track-gain sample.
        do_clear();
        for (int i = 1; i <= 64; i++) begin
            push(16'h0100, t, o, lk);
            if (i == 63) check("lock_63_locked", {31'b0, lk}, 32'd0);
        end
        check("lock_64_locked", {31'b0, lk}, 32'd1);
        check("lock_64_data", o, 32'h0020_0000);
        push(16'h0100, t, o, lk);
        check("lock_65_trk_gain", o, 32'h0014_0400);
        check("lock_65_locked", {31'b0, lk}, 32'd1);

        // Loss of lock after 16 out-of-lock samples.
        for (int i = 1; i <= 16; i++) begin
            push(16'h0400, t, o, lk);
            if (i == 15) check("unlock_15_locked", {31'b0, lk}, 32'd1);
        end
        check("unlock_16_locked", {31'b0, lk}, 32'd0);
        check("unlock_16_data", o, 32'h0021_0400);

        // An interrupted run does not lock; the run after it locks on its 64th sample.
        for (int i = 0; i < 63; i++) push(16'h0100, t, o, lk);
        push(16'hFE00, t, o, lk);
        for (int i = 0; i < 63; i++) push(16'h0100, t, o, lk);
        check("broken_run_locked", {31'b0, lk}, 32'd0);
        push(16'hFF00, t, o, lk);
        check("run_64th_locked", {31'b0, lk}, 32'd1);
        prev = o;

        // Clear with valid while one sample is in flight.
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b1;
        lf.LoopFilterInputData  = 16'h0400;
        @(posedge clk); #1;
        lf.LoopFilterClear = 1'b1;
        @(posedge clk); #1;
        lf.LoopFilterClear      = 1'b0;
        lf.LoopFilterInputValid = 1'b0;
        ok = 1'b1;
        @(negedge clk);
        check("clr_locked", {31'b0, lf.LoopFilterLocked}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (lf.LoopFilterOutputValid !== 1'b0 || lf.LoopFilterOutputData !== prev) ok = 1'b0;
            @(negedge clk);
        end
        check("clr_no_output_hold", {31'b0, ok}, 32'd1);
        push(16'h0400, t, o, lk);
        check("clr_next_data", o, 32'h0041_0000);
        check("clr_next_locked", {31'b0, lk}, 32'd0);

        // Async reset mid-stream from a locked state with one sample in flight.
        do_clear();
        for (int i = 0; i < 64; i++) push(16'h0100, t, o, lk);
        check("pre_rst_locked", {31'b0, lk}, 32'd1);
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b1;
        lf.LoopFilterInputData  = 16'h0400;
        @(posedge clk); #1;
        lf.LoopFilterInputValid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_data", lf.LoopFilterOutputData, 32'd0);
        check("rst_locked", {31'b0, lf.LoopFilterLocked}, 32'd0);
        #1 rstn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lf.LoopFilterOutputValid !== 1'b0) ok = 1'b0;
        end
        check("rst_no_output", {31'b0, ok}, 32'd1);
        push(16'h0400, t, o, lk);
        check("rst_restart_timing", {31'b0, t}, 32'd1);
        check("rst_restart_data", o, 32'h0041_0000);
        check("rst_restart_locked", {31'b0, lk}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
